// File: rtl/sram_model_pkg.sv
// Shared definitions for the SRAM behavioural models.
//   - sram_state_e : init/run state of the post-reset initialisation engine
//   - lane_count() : ceil(width / lane), used to size write-mask ports
//   - RdLatencyMin/RdLatencyMax : legal range for the read pipeline depth
package sram_model_pkg;

  typedef enum logic {
    StInit,
    StRun
  } sram_state_e;

  localparam int unsigned RdLatencyMin = 1;
  localparam int unsigned RdLatencyMax = 4;

  // Number of mask lanes; the last lane covers any remaining bits.
  function automatic int unsigned lane_count(input int unsigned width, input int unsigned lane);
    return (width + lane - 1) / lane;
  endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-data delay line: DEPTH stages of data+valid followed by an output register
// that only loads when the last stage is valid, so the output holds between reads.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low clear of all stages and outputs
//   in_vld, in_data   : word entering stage 1
//   out_vld, out_data : registered output; out_data holds while out_vld is low
module sram_rd_pipe #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_vld,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_vld,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] stage_data_q [DEPTH];
  logic             stage_vld_q  [DEPTH];
  logic [WIDTH-1:0] out_data_q;
  logic             out_vld_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_data_q[i] <= '0;
        stage_vld_q[i]  <= 1'b0;
      end
      out_data_q <= '0;
      out_vld_q  <= 1'b0;
    end else begin
      stage_data_q[0] <= in_data;
      stage_vld_q[0]  <= in_vld;
      for (int i = 1; i < DEPTH; i++) begin
        stage_data_q[i] <= stage_data_q[i-1];
        stage_vld_q[i]  <= stage_vld_q[i-1];
      end
      out_vld_q <= stage_vld_q[DEPTH-1];
      if (stage_vld_q[DEPTH-1]) begin
        out_data_q <= stage_data_q[DEPTH-1];
      end
    end
  end

  assign out_vld  = out_vld_q;
  assign out_data = out_data_q;

endmodule

// File: rtl/sram_sdp_pipe_model.sv
// Simple-dual-port SRAM behavioural model with per-lane write mask, RD_LATENCY-deep
// read pipeline with valid strobe, and a sequential post-reset init engine that
// writes INIT_VALUE to every word before any access is accepted.
// Optional feature macro: SRAM_SDP_RD_FWD_EN -- same-cycle same-address read/write
// returns the merged (new masked lanes, old unmasked lanes) word instead of the old one.
// Ports:
//   clk, rst_n                           : clock, asynchronous active-low reset
//   sram_wr_cen/_a/_d/_mask              : write port (cen active-low, mask 1 = write lane)
//   sram_rd_cen/_a                       : read port (cen active-low)
//   sram_rd_q, sram_rd_vld               : read data and its valid strobe
//   init_done                            : high once the init engine has finished
module sram_sdp_pipe_model
  import sram_model_pkg::*;
#(
  parameter int unsigned            DATA_WIDTH = 88,
  parameter int unsigned            ADDR_WIDTH = 10,
  parameter int unsigned            RAM_DEPTH  = 1024,
  parameter int unsigned            LANE_WIDTH = 8,
  parameter int unsigned            RD_LATENCY = 1,
  parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = {DATA_WIDTH{1'b0}},
  localparam int unsigned           MASK_WIDTH = lane_count(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  sram_wr_cen,
  input  logic [ADDR_WIDTH-1:0] sram_wr_a,
  input  logic [DATA_WIDTH-1:0] sram_wr_d,
  input  logic [MASK_WIDTH-1:0] sram_wr_mask,
  input  logic                  sram_rd_cen,
  input  logic [ADDR_WIDTH-1:0] sram_rd_a,
  output logic [DATA_WIDTH-1:0] sram_rd_q,
  output logic                  sram_rd_vld,
  output logic                  init_done
);

  // Elaboration-time parameter checks.
  if (RD_LATENCY < RdLatencyMin || RD_LATENCY > RdLatencyMax) begin : gen_bad_latency
    $error("sram_sdp_pipe_model: RD_LATENCY must be in 1..4");
  end
  if (RAM_DEPTH > (64'd1 << ADDR_WIDTH)) begin : gen_bad_depth
    $error("sram_sdp_pipe_model: RAM_DEPTH exceeds 2**ADDR_WIDTH");
  end

  localparam logic [ADDR_WIDTH:0]   DepthW   = (ADDR_WIDTH + 1)'(RAM_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(RAM_DEPTH - 1);

  // Storage is deliberately not reset; the init engine clears it.
  logic [DATA_WIDTH-1:0] mem_q [RAM_DEPTH];

  sram_state_e           state_q;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic                  init_done_q;

  logic                  run;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_req;
  logic                  rd_req;
  logic [DATA_WIDTH-1:0] wr_bit_mask;
  logic [DATA_WIDTH-1:0] wr_old;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic [DATA_WIDTH-1:0] rd_old;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  // Init engine: one INIT_VALUE write per cycle, RUN after the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StInit;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        StInit: begin
          if (cnt_q == LastAddr) begin
            state_q     <= StRun;
            init_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StRun: begin
          state_q <= StRun;
        end
        default: begin
          state_q     <= StInit;
          cnt_q       <= '0;
          init_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign run       = (state_q == StRun);
  assign init_done = init_done_q;

  always_comb begin
    wr_in_range = ({1'b0, sram_wr_a} < DepthW);
    rd_in_range = ({1'b0, sram_rd_a} < DepthW);
    wr_req      = run && !sram_wr_cen && wr_in_range;
    rd_req      = run && !sram_rd_cen;

    // Expand lane mask to a per-bit mask.
    wr_bit_mask = '0;
    for (int b = 0; b < DATA_WIDTH; b++) begin
      wr_bit_mask[b] = sram_wr_mask[b / LANE_WIDTH];
    end

    wr_old    = wr_in_range ? mem_q[sram_wr_a] : '0;
    wr_merged = (wr_old & ~wr_bit_mask) | (sram_wr_d & wr_bit_mask);

    // Init writes take the port unconditionally; RUN writes need a non-empty mask.
    mem_we    = !run || (wr_req && (|sram_wr_mask));
    mem_waddr = run ? sram_wr_a : cnt_q;
    mem_wdata = run ? wr_merged : INIT_VALUE;

    // Out-of-range reads still produce a valid strobe, with zero data.
    rd_old = rd_in_range ? mem_q[sram_rd_a] : '0;
`ifdef SRAM_SDP_RD_FWD_EN
    rd_word = (wr_req && rd_in_range && (sram_rd_a == sram_wr_a)) ? wr_merged : rd_old;
`else
    rd_word = rd_old;
`endif
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  sram_rd_pipe #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (RD_LATENCY)
  ) u_rd_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (rd_req),
    .in_data  (rd_word),
    .out_vld  (sram_rd_vld),
    .out_data (sram_rd_q)
  );

endmodule
